ifetch: RTL
===========

Name: ifetch

Overview:
- Instruction fetch and prefetch stage directly upstream of the compressed-instruction decoder.
- Issues aligned 32-bit reads to the instruction memory port and splits each returned word into two 16-bit parcels.
- Buffers the parcels in a small halfword queue and presents one parcel per cycle (ins/idone) to decode.
- Flushes the queue and restarts at a new PC on redirect (branch, jump, trap, reset).

Parameters:
- RV, 32, register and address width; 16 also legal.
- DEPTH, 4, halfword queue entries; power of two, minimum 4.
- RESET_PC, 0, first fetch address after reset; halfword aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  RV  new PC; bit 0 ignored.
- take  in  1  decode consumes the current parcel this cycle.
- ins  out  16  current parcel (queue head).
- ins_pc  out  RV  byte address of ins.
- ins_fault  out  1  parcel came from a faulting fetch.
- idone  out  1  ins, ins_pc and ins_fault are valid.
- ireq  out  1  memory read request.
- iaddr  out  RV  word address; bits [1:0] always 0.
- iack  in  1  request complete; irdata and ifault valid this cycle.
- irdata  in  32  fetched word; little-endian, parcel 0 = [15:0].
- ifault  in  1  fetch error for this word.

Behaviour:
- Reset (asynchronous assert): ireq=0, idone=0, queue count=0, ins_fault=0, fetch PC=RESET_PC, ins/ins_pc=0, state=IDLE.
- Memory handshake:
  - A request completes in any cycle where ireq=1 and iack=1.
  - ireq and iaddr are held stable until iack; a request is never withdrawn.
  - At most one request is outstanding.
  - iack with ireq=0 is ignored.
- Issue rule: a new request may start only when free entries >= 2, counting the push and pop happening this cycle. ireq may be reasserted in the cycle after an ack.
- Response:
  - If fetch PC bit 1 is set (first word after a redirect to an odd halfword), only irdata[31:16] is pushed.
  - Otherwise both halves are pushed, [15:0] first.
  - Each entry stores {parcel, pc, fault}.
  - Fetch PC advances to the next word boundary.
- ifault: the word is pushed with fault=1. Fetching then stops (state HALT) until redirect.
- Output:
  - idone = (count != 0).
  - ins, ins_pc and ins_fault show the head combinationally from the queue registers.
  - take with idone=1 pops one entry. take with idone=0 is ignored.
  - Push and pop in the same cycle are legal.
- States:
  - IDLE: no request outstanding. Goes to REQ when the issue rule is met and not halted.
  - REQ: ireq=1. On iack: push, then go to IDLE, or to REQ again if the issue rule still holds.
  - DISCARD: old request still outstanding after a redirect. ireq stays 1 at the old iaddr; the data at iack is dropped; then REQ at the new PC.
  - HALT: no requests. Leaves only on redirect.
- Redirect (highest priority):
  - Queue is cleared the same cycle. Any take that cycle is ignored; any iack data that cycle is dropped.
  - Fetch PC = redirect_pc with bit 0 cleared.
  - If a request is outstanding and not acked this cycle, go to DISCARD; otherwise go to REQ.
  - idone=0 in the following cycle.
- Latency: redirect in cycle N with no outstanding request gives ireq in N+1. iack in N+1 gives idone in N+2.
- Redirect during DISCARD: update the target PC and stay in DISCARD.
- Full queue: never overflows, because the issue rule reserves space before requesting.
- Address wrap: fetch PC wraps modulo 2^RV with no special handling.

Decomposition:
- Shared package vc32_pkg holds:
  - the fetch-state encoding (IDLE, REQ, DISCARD, HALT);
  - the queue-entry struct {parcel[15:0], pc[RV-1:0], fault};
  - RESET_PC default.
- Sub-module ifetch_queue:
  - halfword FIFO, DEPTH entries;
  - 0/1/2 pushes and 0/1 pop per cycle;
  - synchronous clear;
  - outputs count and head.
- ifetch itself contains the state machine, fetch PC and issue logic.

Test Plan:
- Reset release, RESET_PC=0, memory acks in 1 cycle returning 0x11112222 then 0x33334444, take held 1 -> ins sequence 0x2222@0, 0x1111@2, 0x4444@4, 0x3333@6; iaddr 0, 4, 8...
- take held 0, DEPTH=4 -> exactly two words fetched (count=4), ireq stays 0 until a take, first re-request issued only when free entries >= 2.
- Redirect to 0x102 while idle -> iaddr=0x100 next cycle, ack 0xAAAABBBB -> only 0xAAAA pushed with ins_pc=0x102, next iaddr=0x104.
- Redirect while request outstanding, iack delayed 3 cycles -> ireq held at old iaddr, returned data dropped (idone stays 0), then iaddr = new PC.
- iack with ifault=1 at 0x20 -> two parcels with ins_fault=1, no further ireq; redirect to 0x40 -> fetching resumes at 0x40.
- redirect, take and iack all in the same cycle -> queue empty next cycle, ack data discarded, no pop underflow, ireq to the new PC next cycle.

Source files
------------

// File: rtl/vc32_pkg.sv
// rtl/vc32_pkg.sv - shared fetch-state encoding, queue-entry type and reset PC default
package vc32_pkg;

  localparam int unsigned RV_MAX = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_e;

  // pc is sized for the widest legal RV; narrower cores use the low bits
  typedef struct packed {
    logic [15:0]       parcel;
    logic [RV_MAX-1:0] pc;
    logic              fault;
  } qentry_t;

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - halfword FIFO accepting up to two pushes and one pop per cycle
module ifetch_queue
  import vc32_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [1:0]             push_cnt,
  input  qentry_t                push0,
  input  qentry_t                push1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output qentry_t                head
);

  localparam int unsigned AW = $clog2(DEPTH);

  qentry_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (push_cnt != 2'd0) r_mem[r_wp] <= push0;
      if (push_cnt == 2'd2) r_mem[r_wp + AW'(1)] <= push1;
      r_wp <= r_wp + AW'(push_cnt);
      if (pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(push_cnt) - (AW+1)'(pop);
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rp];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - word fetch with halfword prefetch queue feeding the compressed decoder
module ifetch
  import vc32_pkg::*;
#(
  parameter int unsigned   RV       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [RV-1:0] RESET_PC = RV'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  input  logic          take,
  output logic [15:0]   ins,
  output logic [RV-1:0] ins_pc,
  output logic          ins_fault,
  output logic          idone,
  output logic          ireq,
  output logic [RV-1:0] iaddr,
  input  logic          iack,
  input  logic [31:0]   irdata,
  input  logic          ifault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  logic [RV-1:0] r_pc;
  logic [RV-1:0] r_iaddr;
  logic          r_ireq;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    w_npush;
  logic          w_ack;
  logic          w_pop;
  logic          w_issue_ok;
  logic [RV-1:0] w_word;
  logic [RV-1:0] w_next_word;
  logic [RV-1:0] w_redir_pc;
  qentry_t       w_e0;
  qentry_t       w_e1;
  qentry_t       w_head;

  assign w_ack       = r_ireq & iack;
  assign w_pop       = take & idone & ~redirect;
  assign w_npush     = (redirect || r_state != S_REQ || !w_ack) ? 2'd0 :
                       (r_pc[1] ? 2'd1 : 2'd2);
  assign w_cnt_next  = redirect ? '0 : w_count + CW'(w_npush) - CW'(w_pop);
  // space for a whole word must exist after this cycle's push and pop
  assign w_issue_ok  = (CW'(DEPTH) - w_cnt_next) >= CW'(2);
  assign w_word      = r_pc & ~RV'(3);
  assign w_next_word = w_word + RV'(4);
  assign w_redir_pc  = redirect_pc & ~RV'(1);

  always_comb begin
    w_e0        = '0;
    w_e1        = '0;
    w_e0.parcel = r_pc[1] ? irdata[31:16] : irdata[15:0];
    w_e0.pc     = RV_MAX'(r_pc[1] ? r_pc : w_word);
    w_e0.fault  = ifault;
    w_e1.parcel = irdata[31:16];
    w_e1.pc     = RV_MAX'(w_word + RV'(2));
    w_e1.fault  = ifault;
  end

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (redirect),
    .push_cnt (w_npush),
    .push0    (w_e0),
    .push1    (w_e1),
    .pop      (w_pop),
    .count    (w_count),
    .head     (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_iaddr <= '0;
      r_ireq  <= 1'b0;
    end else if (redirect) begin
      r_pc <= w_redir_pc;
      if (r_ireq && !iack) begin
        r_state <= S_DISCARD;
      end else begin
        r_state <= S_REQ;
        r_ireq  <= 1'b1;
        r_iaddr <= w_redir_pc & ~RV'(3);
      end
    end else begin
      case (r_state)
        S_IDLE: if (w_issue_ok) begin
          r_state <= S_REQ;
          r_ireq  <= 1'b1;
          r_iaddr <= w_word;
        end
        S_REQ: if (iack) begin
          if (ifault) begin
            r_state <= S_HALT;
            r_ireq  <= 1'b0;
          end else begin
            r_pc <= w_next_word;
            if (w_issue_ok) begin
              r_iaddr <= w_next_word;
            end else begin
              r_state <= S_IDLE;
              r_ireq  <= 1'b0;
            end
          end
        end
        // stale word is dropped; the new target is requested straight away
        S_DISCARD: if (iack) begin
          r_state <= S_REQ;
          r_iaddr <= w_word;
        end
        S_HALT:  r_ireq  <= 1'b0;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ireq      = r_ireq;
  assign iaddr     = r_iaddr;
  assign idone     = (w_count != '0);
  assign ins       = w_head.parcel;
  assign ins_pc    = w_head.pc[RV-1:0];
  assign ins_fault = w_head.fault;

endmodule
